// File: rtl/mem_stage.sv
// Memory-access stage: issues one word-aligned cache request per load/store, extends load data for write-back.
// Non-memory ops retire in 1 cycle; memory ops stall upstream via mem_stall until dc_ack (or timeout).
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_we,
    input  logic        ex_mem_re,
    input  logic        ex_mem_we,
    input  logic [2:0]  ex_funct3,
    output logic        mem_stall,
    output logic        dc_req,
    output logic        dc_we,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    output logic [3:0]  dc_wstrb,
    input  logic        dc_ack,
    input  logic [31:0] dc_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_we,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNT_W-1:0]  r_cnt;
    logic [4:0]        r_rd;
    logic              r_reg_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;

    logic              r_dc_req;
    logic              r_dc_we;
    logic [31:0]       r_dc_addr;
    logic [31:0]       r_dc_wdata;
    logic [3:0]        r_dc_wstrb;
    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic              r_wb_reg_we;
    logic [31:0]       r_wb_data;
    logic              r_mem_err;

    logic              w_mem_op;
    logic              w_legal;
    logic              w_aligned;
    logic              w_good;
    logic              w_accept;
    logic              w_ack;
    logic              w_timeout;
    logic              w_bad;
    logic              w_pass;
    logic [31:0]       w_wdata;
    logic [3:0]        w_wstrb;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;

    assign w_mem_op = ex_valid & (ex_mem_re | ex_mem_we);

    // Signed sub-word forms (100/101) exist only for loads.
    always_comb begin
        w_legal = 1'b0;
        case (ex_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = ex_mem_re;
            default:                w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_aligned = 1'b1;
        case (ex_funct3[1:0])
            2'b01:   w_aligned = ~ex_alu_out[0];
            2'b10:   w_aligned = (ex_alu_out[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    assign w_good = w_mem_op & w_legal & w_aligned;

    always_comb begin
        w_wdata = ex_rs2_data;
        w_wstrb = 4'b1111;
        case (ex_funct3[1:0])
            2'b00: begin
                w_wdata = {4{ex_rs2_data[7:0]}};
                w_wstrb = 4'b0001 << ex_alu_out[1:0];
            end
            2'b01: begin
                w_wdata = {2{ex_rs2_data[15:0]}};
                w_wstrb = 4'b0011 << ex_alu_out[1:0];
            end
            default: begin
                w_wdata = ex_rs2_data;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_byte = dc_rdata[7:0];
        case (r_off)
            2'b00:   w_byte = dc_rdata[7:0];
            2'b01:   w_byte = dc_rdata[15:8];
            2'b10:   w_byte = dc_rdata[23:16];
            default: w_byte = dc_rdata[31:24];
        endcase
    end

    assign w_half = r_off[1] ? dc_rdata[31:16] : dc_rdata[15:0];

    always_comb begin
        w_load_data = dc_rdata;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = dc_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_good) begin
                    w_state_nxt = S_WAIT;
                    w_accept    = 1'b1;
                end
            end
            S_WAIT: begin
                if (dc_ack) begin
                    w_state_nxt = S_IDLE;
                    w_ack       = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_bad  = (r_state == S_IDLE) & w_mem_op & ~w_good;
    assign w_pass = (r_state == S_IDLE) & ex_valid & ~w_mem_op;

    // Low in the ack cycle so upstream advances on the same edge the access completes.
    assign mem_stall = ((r_state == S_IDLE) & w_good) | ((r_state == S_WAIT) & ~dc_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rd        <= 5'd0;
            r_reg_we    <= 1'b0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_dc_req    <= 1'b0;
            r_dc_we     <= 1'b0;
            r_dc_addr   <= 32'd0;
            r_dc_wdata  <= 32'd0;
            r_dc_wstrb  <= 4'd0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_reg_we <= 1'b0;
            r_wb_data   <= 32'd0;
            r_mem_err   <= 1'b0;
        end else begin
            r_mem_err <= w_bad | w_timeout;
            if (w_accept) begin
                r_dc_req   <= 1'b1;
                r_dc_we    <= ex_mem_we;
                r_dc_addr  <= {ex_alu_out[31:2], 2'b00};
                r_dc_wdata <= w_wdata;
                r_dc_wstrb <= ex_mem_we ? w_wstrb : 4'b0000;
                r_rd       <= ex_rd;
                r_reg_we   <= ex_reg_we;
                r_funct3   <= ex_funct3;
                r_off      <= ex_alu_out[1:0];
                r_cnt      <= '0;
                r_wb_valid <= 1'b0;
            end else if (w_pass) begin
                r_wb_valid  <= 1'b1;
                r_wb_rd     <= ex_rd;
                r_wb_reg_we <= ex_reg_we;
                r_wb_data   <= ex_alu_out;
            end else if (w_bad) begin
                r_wb_valid  <= 1'b1;
                r_wb_rd     <= ex_rd;
                r_wb_reg_we <= 1'b0;
                r_wb_data   <= 32'd0;
            end else if (w_ack) begin
                r_dc_req    <= 1'b0;
                r_wb_valid  <= 1'b1;
                r_wb_rd     <= r_rd;
                r_wb_reg_we <= r_reg_we & ~r_dc_we;
                r_wb_data   <= r_dc_we ? 32'd0 : w_load_data;
            end else if (w_timeout) begin
                r_dc_req    <= 1'b0;
                r_wb_valid  <= 1'b1;
                r_wb_rd     <= r_rd;
                r_wb_reg_we <= 1'b0;
                r_wb_data   <= 32'd0;
            end else begin
                r_wb_valid <= 1'b0;
                if (r_state == S_WAIT) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign dc_req    = r_dc_req;
    assign dc_we     = r_dc_we;
    assign dc_addr   = r_dc_addr;
    assign dc_wdata  = r_dc_wdata;
    assign dc_wstrb  = r_dc_wstrb;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_reg_we = r_wb_reg_we;
    assign wb_data   = r_wb_data;
    assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: transaction-level model plus per-cycle output compare.
module tb_mem_stage;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_alu_out = 32'd0;
    logic [31:0] ex_rs2_data = 32'd0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_reg_we = 1'b0;
    logic        ex_mem_re = 1'b0;
    logic        ex_mem_we = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic        dc_ack = 1'b0;
    logic [31:0] dc_rdata = 32'd0;
    logic        mem_stall, dc_req, dc_we, wb_valid, wb_reg_we, mem_err;
    logic [31:0] dc_addr, dc_wdata, wb_data;
    logic [3:0]  dc_wstrb;
    logic [4:0]  wb_rd;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
        .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
        .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_funct3(ex_funct3),
        .mem_stall(mem_stall), .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb), .dc_ack(dc_ack), .dc_rdata(dc_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_data(wb_data),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic        reg_we;
        logic        chk_data;
        logic [31:0] data;
        logic        err;
    } wb_exp_t;

    wb_exp_t     q[$];
    logic        acc_vld = 1'b0;
    logic        acc_we = 1'b0;
    logic [31:0] acc_addr = 32'd0;
    logic [31:0] acc_wdata = 32'd0;
    logic [3:0]  acc_strb = 4'd0;

    // Expected outcome of one instruction, from access size in bytes and byte offset.
    task automatic model(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic rwe, input logic re, input logic mwe, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic tmo, output wb_exp_t e,
                         output logic acc, output logic [31:0] a_addr, output logic [31:0] a_wdata,
                         output logic [3:0] a_strb);
        int nb;
        int off;
        logic legal;
        logic [31:0] v;
        nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(alu[1:0]);
        legal = re ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        e.rd = rd; e.err = 1'b0; e.chk_data = 1'b1; e.reg_we = 1'b0; e.data = 32'd0;
        acc = 1'b0; a_addr = 32'd0; a_wdata = 32'd0; a_strb = 4'd0;
        if (!(re || mwe)) begin
            e.reg_we = rwe;
            e.data   = alu;
        end else if (!legal || (off % nb) != 0) begin
            e.err = 1'b1; e.chk_data = 1'b0;
        end else begin
            acc    = 1'b1;
            a_addr = alu & ~32'd3;
            a_strb = mwe ? 4'(((1 << nb) - 1) << off) : 4'd0;
            for (int k = 0; k < 4; k++) a_wdata[8*k +: 8] = rs2[8*(k % nb) +: 8];
            if (tmo) begin
                e.err = 1'b1; e.chk_data = 1'b0;
            end else if (mwe) begin
                e.data = 32'd0;
            end else begin
                e.reg_we = rwe;
                v = rdata >> (8 * off);
                if (nb == 1) begin
                    v = v & 32'hFF;
                    if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
                end else if (nb == 2) begin
                    v = v & 32'hFFFF;
                    if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
                end
                e.data = v;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_valid) begin
                if (q.size() == 0) begin
                    chk("wb_unexpected", wb_valid, 1'b0);
                end else begin
                    wb_exp_t e;
                    e = q.pop_front();
                    chk("wb_reg_we", wb_reg_we, e.reg_we);
                    chk("wb_mem_err", mem_err, e.err);
                    if (!e.err) chk("wb_rd", wb_rd, e.rd);
                    if (e.chk_data) chk("wb_data", wb_data, e.data);
                end
            end else begin
                chk("mem_err_quiet", mem_err, 1'b0);
            end
            if (dc_req) begin
                if (!acc_vld) begin
                    chk("dc_req_unexpected", dc_req, 1'b0);
                end else begin
                    chk("dc_addr", dc_addr, acc_addr);
                    chk("dc_we", dc_we, acc_we);
                    chk("dc_wstrb", dc_wstrb, acc_strb);
                    if (acc_we) chk("dc_wdata", dc_wdata, acc_wdata);
                end
            end
        end
    end

    // Presents one instruction, holds it while stalled, acks after ack_after request cycles (<0: never).
    task automatic run_instr(input string name, input logic [31:0] alu, input logic [31:0] rs2,
                             input logic [4:0] rd, input logic rwe, input logic re, input logic mwe,
                             input logic [2:0] f3, input int ack_after, input logic [31:0] rdata,
                             output int n_stall, output int n_req);
        wb_exp_t e;
        logic acc;
        logic [31:0] aa, aw;
        logic [3:0] as;
        bit fin;
        model(alu, rs2, rd, rwe, re, mwe, f3, rdata, ack_after < 0, e, acc, aa, aw, as);
        q.push_back(e);
        acc_vld = acc; acc_we = mwe; acc_addr = aa; acc_wdata = aw; acc_strb = as;
        ex_valid = 1'b1; ex_alu_out = alu; ex_rs2_data = rs2; ex_rd = rd; ex_reg_we = rwe;
        ex_mem_re = re; ex_mem_we = mwe; ex_funct3 = f3; dc_rdata = rdata;
        n_stall = 0; n_req = 0; fin = 0;
        for (int c = 0; c < 100 && !fin; c++) begin
            dc_ack = dc_req && (ack_after >= 0) && (n_req == ack_after);
            @(negedge clk);
            if (mem_stall) n_stall++;
            if (dc_req) n_req++;
            @(posedge clk);
            #1;
            dc_ack = 1'b0;
            if (wb_valid) fin = 1;
        end
        if (!fin) chk({name, "_no_completion"}, 32'd0, 32'd1);
        ex_valid = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b0;
        acc_vld = 1'b0;
    endtask

    initial begin
        wb_exp_t pe;
        logic pacc;
        logic [31:0] pa, pw;
        logic [3:0] ps;
        int s, r;

        // Pin the model against hand-computed values.
        model(32'h201, 32'hAABBCCDD, 5'd1, 1'b0, 1'b0, 1'b1, 3'b000, 32'd0, 1'b0, pe, pacc, pa, pw, ps);
        chk("model_sb_addr", pa, 32'h200);
        chk("model_sb_wdata", pw, 32'hDDDDDDDD);
        chk("model_sb_strb", ps, 4'b0010);
        model(32'h103, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 32'h80FFFFFF, 1'b0, pe, pacc, pa, pw, ps);
        chk("model_lb_data", pe.data, 32'hFFFFFF80);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_dc_req", dc_req, 1'b0);
        chk("rst_dc_addr", dc_addr, 32'd0);
        chk("rst_dc_wstrb", dc_wstrb, 4'd0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_mem_err", mem_err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_instr("alu", 32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, -1, 32'd0, s, r);
        chk("alu_wb_data", wb_data, 32'h1234);
        chk("alu_wb_rd", wb_rd, 5'd5);
        chk("alu_stall", s, 0);
        chk("alu_req", r, 0);

        run_instr("lb", 32'h103, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 3, 32'h80FFFFFF, s, r);
        chk("lb_wb_data", wb_data, 32'hFFFFFF80);
        chk("lb_stall", s, 4);
        chk("lb_req", r, 4);

        run_instr("lhu", 32'h102, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b101, 1, 32'h80010000, s, r);
        chk("lhu_wb_data", wb_data, 32'h00008001);
        run_instr("lh", 32'h102, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b001, 2, 32'h80010000, s, r);
        chk("lh_wb_data", wb_data, 32'hFFFF8001);

        run_instr("sb", 32'h201, 32'hAABBCCDD, 5'd10, 1'b1, 1'b0, 1'b1, 3'b000, 2, 32'd0, s, r);
        chk("sb_wb_reg_we", wb_reg_we, 1'b0);

        run_instr("lw_mis", 32'h006, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b010, 0, 32'd0, s, r);
        chk("lw_mis_err", mem_err, 1'b1);
        chk("lw_mis_we", wb_reg_we, 1'b0);
        chk("lw_mis_req", r, 0);
        chk("lw_mis_stall", s, 0);
        run_instr("sh_mis", 32'h003, 32'h5555, 5'd12, 1'b0, 1'b0, 1'b1, 3'b001, 0, 32'd0, s, r);
        chk("sh_mis_err", mem_err, 1'b1);
        chk("sh_mis_req", r, 0);
        run_instr("sbu_ill", 32'h010, 32'h1, 5'd13, 1'b0, 1'b0, 1'b1, 3'b100, 0, 32'd0, s, r);
        chk("sbu_ill_err", mem_err, 1'b1);
        run_instr("ld_ill", 32'h000, 32'd0, 5'd14, 1'b1, 1'b1, 1'b0, 3'b011, 0, 32'd0, s, r);
        chk("ld_ill_err", mem_err, 1'b1);

        run_instr("sw", 32'h40, 32'h12345678, 5'd15, 1'b0, 1'b0, 1'b1, 3'b010, 0, 32'd0, s, r);
        chk("sw_stall", s, 1);
        run_instr("lw_b2b", 32'h44, 32'd0, 5'd16, 1'b1, 1'b1, 1'b0, 3'b010, 0, 32'hCAFEBABE, s, r);
        chk("lw_b2b_data", wb_data, 32'hCAFEBABE);
        chk("lw_b2b_req", r, 1);
        run_instr("lbu", 32'h41, 32'd0, 5'd17, 1'b1, 1'b1, 1'b0, 3'b100, 1, 32'h00009A00, s, r);
        chk("lbu_data", wb_data, 32'h0000009A);
        run_instr("sh", 32'h42, 32'hFFFF1357, 5'd18, 1'b0, 1'b0, 1'b1, 3'b001, 1, 32'd0, s, r);
        run_instr("alu_nowe", 32'hDEADBEEF, 32'd0, 5'd19, 1'b0, 1'b0, 1'b0, 3'b000, -1, 32'd0, s, r);

        run_instr("tmo", 32'h80, 32'd0, 5'd20, 1'b1, 1'b1, 1'b0, 3'b010, -1, 32'd0, s, r);
        chk("tmo_req", r, TO);
        chk("tmo_stall", s, TO + 1);
        chk("tmo_err", mem_err, 1'b1);
        chk("tmo_dc_req_low", dc_req, 1'b0);

        dc_ack = 1'b1;
        @(negedge clk);
        chk("idle_ack_stall", mem_stall, 1'b0);
        @(posedge clk);
        #1;
        dc_ack = 1'b0;
        chk("idle_ack_wbv", wb_valid, 1'b0);
        chk("idle_ack_req", dc_req, 1'b0);

        model(32'h100, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010, 32'd0, 1'b1, pe, pacc, pa, pw, ps);
        acc_vld = pacc; acc_we = 1'b0; acc_addr = pa; acc_wdata = pw; acc_strb = ps;
        ex_valid = 1'b1; ex_alu_out = 32'h100; ex_rd = 5'd3; ex_reg_we = 1'b1;
        ex_mem_re = 1'b1; ex_mem_we = 1'b0; ex_funct3 = 3'b010;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_mid_pre_req", dc_req, 1'b1);
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_mem_re = 1'b0;
        #1;
        chk("rst_mid_req", dc_req, 1'b0);
        chk("rst_mid_wbv", wb_valid, 1'b0);
        chk("rst_mid_stall", mem_stall, 1'b0);
        acc_vld = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr("alu_post", 32'h77, 32'd0, 5'd21, 1'b1, 1'b0, 1'b0, 3'b000, -1, 32'd0, s, r);
        chk("alu_post_data", wb_data, 32'h77);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the five-stage pipeline, directly downstream of the execute ALU.
- Consumes the ALU result as the effective address or pass-through value, and the rs2 value as store data.
- Issues word-aligned requests to the data cache through a req/ack handshake and stalls upstream stages while a request is outstanding.
- Sign- or zero-extends load data and presents a registered result to write-back.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT without dc_ack before the access is abandoned; must be ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_alu_out  in  32  ALU result: address for load/store, value otherwise.
- ex_rs2_data  in  32  store data.
- ex_rd  in  5  destination register.
- ex_reg_we  in  1  instruction writes rd.
- ex_mem_re  in  1  load.
- ex_mem_we  in  1  store; ex_mem_re and ex_mem_we are never both 1.
- ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_stall  out  1  combinational; upstream holds its EX outputs while 1.
- dc_req  out  1  cache request, registered.
- dc_we  out  1  1 = write.
- dc_addr  out  32  {addr[31:2],2'b00}.
- dc_wdata  out  32  lane-replicated store data.
- dc_wstrb  out  4  byte enables; 0000 for reads.
- dc_ack  in  1  one-cycle completion pulse; only sampled in WAIT.
- dc_rdata  in  32  read word, valid in the dc_ack cycle.
- wb_valid  out  1  registered; WB holds a valid result.
- wb_rd  out  5  destination register.
- wb_reg_we  out  1  write-enable to the register file.
- wb_data  out  32  extended load data or pass-through ALU value.
- mem_err  out  1  one-cycle pulse on a misaligned access, an illegal funct3, or a timeout.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE and the timeout counter clears.
  - All registered outputs go to 0: dc_req, dc_we, dc_addr, dc_wdata, dc_wstrb, wb_valid, wb_rd, wb_reg_we, wb_data, mem_err.
  - Reset during WAIT drops dc_req immediately and abandons the access. The cache must tolerate the dropped request.
- States: IDLE and WAIT.
- Access classification, with mem_op = ex_valid & (ex_mem_re | ex_mem_we):
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
  - Aligned: H requires addr[0]=0; W requires addr[1:0]=00.
  - good = mem_op & legal & aligned.
- mem_stall = (IDLE & good) | (WAIT & ~dc_ack). It is 0 in the ack cycle, so upstream advances on that edge.
- IDLE, non-memory instruction (ex_valid & ~mem_op):
  - Next edge: wb_valid=1, wb_rd=ex_rd, wb_reg_we=ex_reg_we, wb_data=ex_alu_out.
  - Latency is 1 cycle with no stall.
- IDLE, mem_op but not good:
  - Next edge: mem_err=1 for one cycle, wb_valid=1, wb_reg_we=0 (instruction retires with no side effect).
  - No cache request is issued.
- IDLE, good:
  - Next edge: enter WAIT and set dc_req=1 and dc_we=ex_mem_we.
  - Latch dc_addr, rd, reg_we, funct3 and addr[1:0]. Clear the counter. wb_valid=0.
  - Store data and strobes:
    - SB: dc_wdata={4{rs2[7:0]}}, dc_wstrb=0001<<addr[1:0].
    - SH: dc_wdata={2{rs2[15:0]}}, dc_wstrb=0011<<addr[1:0].
    - SW: dc_wdata=rs2, dc_wstrb=1111.
    - Loads: dc_wstrb=0000.
- IDLE, ex_valid=0: next edge wb_valid=0.
- WAIT:
  - dc_req and all dc_* outputs stay stable until the ack cycle. wb_valid=0 and the counter increments each cycle.
  - On dc_ack:
    - Next edge: dc_req=0, return to IDLE, wb_valid=1, wb_rd and wb_reg_we from the latched values.
    - Load data: select the byte or half from dc_rdata by the latched addr[1:0]. B/H sign-extend, BU/HU zero-extend, W passes the word.
    - Store: wb_reg_we=0 and wb_data=0.
  - Timeout (counter == TIMEOUT_CYCLES-1 with no ack):
    - Next edge: dc_req=0, mem_err pulse, wb_valid=1, wb_reg_we=0, return to IDLE.
  - A dc_ack arriving in IDLE is ignored.
- Back-to-back memory operations: after an ack, a new good access is accepted in the IDLE cycle that follows, so dc_req has at least one low cycle between requests.

Test Plan:
- Non-memory: ex_alu_out=0x1234 with rd=5, reg_we=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234; mem_stall never rises.
- LB at 0x103, dc_ack 3 cycles after dc_req with dc_rdata=0x80FF_FF_FF -> dc_addr=0x100, wstrb=0000, mem_stall high 4 cycles, then wb_data=0xFFFF_FF80.
- LHU at 0x102 with dc_rdata=0x8001_0000 -> wb_data=0x0000_8001. LH at the same address -> wb_data=0xFFFF_8001.
- SB at 0x201 with rs2=0xAABBCCDD -> dc_addr=0x200, dc_we=1, dc_wdata=0xDDDDDDDD, dc_wstrb=0010; after ack, wb_reg_we=0.
- LW at 0x006 -> no dc_req, mem_err pulses once, wb_valid=1 with wb_reg_we=0. SH at 0x003 -> same response.
- No ack (TIMEOUT_CYCLES=8) -> dc_req high exactly 8 cycles, then mem_err pulse and return to IDLE. Separately, assert rst_n=0 mid-WAIT -> dc_req drops without waiting for a clock edge.
